// File: rtl/stream_fifo_if.sv
// Handshake and status bundle between a stream_fifo and its producer/consumer.
interface stream_fifo_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned ADR   = 10
);
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] datasave;
  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [ADR:0]     count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, rd, datasave, flush, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr, rd, datasave, flush, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/stream_fifo.sv
// Synchronous single-clock FIFO with FWFT or registered-read output, occupancy
// and threshold flags, and sticky overflow/underflow error flags.
module stream_fifo #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned ADR      = 10,
  parameter int unsigned AF_LEVEL = (1 << ADR) - 4,
  parameter int unsigned AE_LEVEL = 4,
  parameter int unsigned FWFT     = 1
) (
  input  logic         pclk,
  input  logic         reset,
  stream_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADR;
  localparam int unsigned CW    = ADR + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [ADR-1:0]   wr_ptr, wr_ptr_nxt;
  logic [ADR-1:0]   rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]    count_q, count_nxt;
  logic             full_q, empty_q, af_q, ae_q;
  logic             ovf_q, unf_q, ovf_nxt, unf_nxt;
  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic             wr_acc, rd_acc, bypass;

  // Next-state for pointers, occupancy, errors and output word
  always_comb begin
    wr_acc     = bus.wr && !full_q && !bus.flush;
    rd_acc     = bus.rd && !empty_q && !bus.flush;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count_q;
    dout_nxt   = dout_q;
    bypass     = 1'b0;

    if (wr_acc) wr_ptr_nxt = wr_ptr + ADR'(1);
    if (rd_acc) rd_ptr_nxt = rd_ptr + ADR'(1);

    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase

    if (bus.flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end

    // Sticky errors: a new rejected request beats clr_err
    ovf_nxt = (bus.wr && full_q && !bus.flush) || (ovf_q && !bus.clr_err);
    unf_nxt = (bus.rd && empty_q && !bus.flush) || (unf_q && !bus.clr_err);

    if (FWFT != 0) begin
      // New head is the word being written when nothing older survives the read
      bypass = wr_acc && ((count_q - CW'(rd_acc)) == '0);
      if (count_nxt != '0) dout_nxt = bypass ? bus.datasave : mem[rd_ptr_nxt];
    end else if (rd_acc) begin
      dout_nxt = mem[rd_ptr];
    end
  end

  // Storage array: no reset so it maps onto block RAM
  always_ff @(posedge pclk) begin
    if (wr_acc) mem[wr_ptr] <= bus.datasave;
  end

  // Control and status registers
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= CW'(AF_LEVEL));
      ae_q    <= (count_nxt <= CW'(AE_LEVEL));
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
      dout_q  <= dout_nxt;
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: one FWFT instance and one registered-read instance.
module tb_stream_fifo;

  logic pclk;
  logic reset_a, reset_b;
  int   tests = 0;
  int   fails = 0;
  logic [9:0] q[$];

  stream_fifo_if #(.WIDTH(10), .ADR(2)) bus_a ();
  stream_fifo_if #(.WIDTH(10), .ADR(2)) bus_b ();

  stream_fifo #(.WIDTH(10), .ADR(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut_a (
    .pclk (pclk), .reset (reset_a), .bus (bus_a.slave)
  );

  stream_fifo #(.WIDTH(10), .ADR(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut_b (
    .pclk (pclk), .reset (reset_b), .bus (bus_b.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_a.wr = 0; bus_a.rd = 0; bus_a.flush = 0; bus_a.clr_err = 0; bus_a.datasave = '0;
    bus_b.wr = 0; bus_b.rd = 0; bus_b.flush = 0; bus_b.clr_err = 0; bus_b.datasave = '0;
    #2;
    chk("rst_count",    32'(bus_a.count), 0);
    chk("rst_empty",    32'(bus_a.empty), 1);
    chk("rst_ae",       32'(bus_a.almost_empty), 1);
    chk("rst_full",     32'(bus_a.full), 0);
    chk("rst_af",       32'(bus_a.almost_full), 0);
    chk("rst_ovf",      32'(bus_a.overflow), 0);
    chk("rst_unf",      32'(bus_a.underflow), 0);
    chk("rst_dout_b",   32'(bus_b.data_out), 0);
    #10;
    reset_a = 1'b0;
    reset_b = 1'b0;

    // Single word into empty FWFT FIFO, first edge after reset release
    bus_a.wr = 1; bus_a.datasave = 10'h2A5;
    tick();
    bus_a.wr = 0;
    chk("fwft1_empty", 32'(bus_a.empty), 0);
    chk("fwft1_dout",  32'(bus_a.data_out), 32'h2A5);
    chk("fwft1_count", 32'(bus_a.count), 1);
    bus_a.rd = 1;
    tick();
    bus_a.rd = 0;
    chk("fwft1_rd_empty", 32'(bus_a.empty), 1);
    chk("fwft1_rd_count", 32'(bus_a.count), 0);

    // Fill to full, then one dropped write
    for (int i = 1; i <= 4; i++) begin
      bus_a.wr = 1; bus_a.datasave = 10'(i);
      tick();
      if (i == 3) begin
        chk("fill3_af",   32'(bus_a.almost_full), 1);
        chk("fill3_full", 32'(bus_a.full), 0);
      end
    end
    chk("fill_full",  32'(bus_a.full), 1);
    chk("fill_count", 32'(bus_a.count), 4);
    chk("fill_dout",  32'(bus_a.data_out), 32'h001);
    chk("fill_ae",    32'(bus_a.almost_empty), 0);
    bus_a.datasave = 10'h005;
    tick();
    bus_a.wr = 0;
    chk("ovf_count", 32'(bus_a.count), 4);
    chk("ovf_flag",  32'(bus_a.overflow), 1);
    bus_a.clr_err = 1;
    tick();
    bus_a.clr_err = 0;
    chk("ovf_clr", 32'(bus_a.overflow), 0);

    // Drain two words to reach count=2
    bus_a.rd = 1;
    tick();
    chk("rd2_dout", 32'(bus_a.data_out), 32'h002);
    tick();
    bus_a.rd = 0;
    chk("rd3_dout",  32'(bus_a.data_out), 32'h003);
    chk("rd3_count", 32'(bus_a.count), 2);

    // Continuous read+write across pointer wrap
    q = {10'h003, 10'h004};
    for (int i = 0; i < 10; i++) begin
      bus_a.wr = 1; bus_a.rd = 1; bus_a.datasave = 10'(32'h100 + i);
      tick();
      void'(q.pop_front());
      q.push_back(10'(32'h100 + i));
      chk("wrap_count", 32'(bus_a.count), 2);
      chk("wrap_dout",  32'(bus_a.data_out), 32'(q[0]));
    end
    bus_a.wr = 0;
    tick();
    chk("wrap_tail_dout", 32'(bus_a.data_out), 32'h109);
    tick();
    bus_a.rd = 0;
    chk("drain_empty", 32'(bus_a.empty), 1);
    chk("drain_count", 32'(bus_a.count), 0);

    // Underflow set / clear / set-beats-clear
    bus_a.rd = 1;
    tick();
    bus_a.rd = 0;
    chk("unf_flag",  32'(bus_a.underflow), 1);
    chk("unf_count", 32'(bus_a.count), 0);
    bus_a.clr_err = 1;
    tick();
    chk("unf_clr", 32'(bus_a.underflow), 0);
    bus_a.rd = 1;
    tick();
    bus_a.rd = 0; bus_a.clr_err = 0;
    chk("unf_set_wins", 32'(bus_a.underflow), 1);
    bus_a.clr_err = 1;
    tick();
    bus_a.clr_err = 0;

    // Empty with wr+rd: only the write is taken
    bus_a.wr = 1; bus_a.rd = 1; bus_a.datasave = 10'h155;
    tick();
    bus_a.rd = 0;
    chk("wr_rd_empty_count", 32'(bus_a.count), 1);
    chk("wr_rd_empty_unf",   32'(bus_a.underflow), 1);
    chk("wr_rd_empty_dout",  32'(bus_a.data_out), 32'h155);
    bus_a.datasave = 10'h156;
    tick();
    bus_a.datasave = 10'h157;
    tick();
    chk("pre_flush_count", 32'(bus_a.count), 3);

    // Flush beats a simultaneous write
    bus_a.flush = 1; bus_a.datasave = 10'h3FF;
    tick();
    bus_a.flush = 0;
    chk("flush_count", 32'(bus_a.count), 0);
    chk("flush_empty", 32'(bus_a.empty), 1);
    chk("flush_ae",    32'(bus_a.almost_empty), 1);
    chk("flush_af",    32'(bus_a.almost_full), 0);
    bus_a.datasave = 10'h0AB;
    tick();
    chk("post_flush_dout",  32'(bus_a.data_out), 32'h0AB);
    chk("post_flush_count", 32'(bus_a.count), 1);

    // Full with wr+rd: only the read is taken
    for (int i = 0; i < 3; i++) begin
      bus_a.datasave = 10'(32'h0AC + i);
      tick();
    end
    chk("refill_full", 32'(bus_a.full), 1);
    bus_a.clr_err = 1;
    tick();
    bus_a.clr_err = 0;
    bus_a.rd = 1; bus_a.datasave = 10'h0AF;
    tick();
    bus_a.wr = 0; bus_a.rd = 0;
    chk("wr_rd_full_count", 32'(bus_a.count), 3);
    chk("wr_rd_full_ovf",   32'(bus_a.overflow), 1);
    chk("wr_rd_full_dout",  32'(bus_a.data_out), 32'h0AC);

    // Registered-read instance
    bus_b.wr = 1; bus_b.datasave = 10'h011;
    tick();
    bus_b.datasave = 10'h022;
    tick();
    bus_b.wr = 0;
    chk("std_count",     32'(bus_b.count), 2);
    chk("std_dout_hold", 32'(bus_b.data_out), 0);
    bus_b.rd = 1;
    tick();
    chk("std_rd1", 32'(bus_b.data_out), 32'h011);
    tick();
    bus_b.rd = 0;
    chk("std_rd2",   32'(bus_b.data_out), 32'h022);
    chk("std_empty", 32'(bus_b.empty), 1);
    bus_b.wr = 1; bus_b.datasave = 10'h033;
    tick();
    chk("std_hold_after_wr", 32'(bus_b.data_out), 32'h022);

    // Asynchronous reset mid-stream, write held high throughout
    reset_b = 1'b1;
    #1;
    chk("async_rst_count", 32'(bus_b.count), 0);
    chk("async_rst_dout",  32'(bus_b.data_out), 0);
    chk("async_rst_empty", 32'(bus_b.empty), 1);
    tick();
    chk("rst_wr_ignored", 32'(bus_b.count), 0);
    reset_b = 1'b0;
    tick();
    bus_b.wr = 0;
    chk("first_wr_after_rst", 32'(bus_b.count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
